// File: rtl/fcvt_s_w.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU: 32-bit integer to IEEE-754 binary32.
// Define FCVT_FAST_NORM_EN for single-cycle normalisation (priority encoder + barrel shift).
module fcvt_s_w #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             signed_op,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             exception
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [2:0]       rm_q, rm_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [7:0]       exp_q, exp_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             exc_q, exc_d;

  logic [22:0] mant;
  logic        lsb, guard, sticky, inc;
  logic [23:0] mant_sum;
  logic [7:0]  exp_rnd;

`ifdef FCVT_FAST_NORM_EN
  function automatic logic [4:0] lead_zeros(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    // Highest set bit is visited last, so it wins.
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  logic [4:0] lz;
  assign lz = lead_zeros(mag_q);
`endif

  assign mant   = mag_q[30:8];
  assign lsb    = mag_q[8];
  assign guard  = mag_q[7];
  assign sticky = |mag_q[6:0];

  always_comb begin
    unique case (rm_q)
      3'd1:    inc = 1'b0;                      // RTZ
      3'd2:    inc = sign_q & (guard | sticky);  // RDN
      3'd3:    inc = ~sign_q & (guard | sticky); // RUP
      3'd4:    inc = guard;                      // RMM
      default: inc = guard & (sticky | lsb);     // RNE, and 5-7
    endcase
  end

  // A mantissa carry leaves sum[22:0] all-zero, which is exactly the renormalised fraction.
  assign mant_sum = {1'b0, mant} + {23'd0, inc};
  assign exp_rnd  = exp_q + {7'd0, mant_sum[23]};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    sign_d  = sign_q;
    rm_d    = rm_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    out_d   = out_q;
    exc_d   = exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = signed_op & a[31];
          mag_d  = sign_d ? (~a + 32'd1) : a;
          rm_d   = rm;
          exp_d  = 8'd158;
          if (mag_d == '0) begin
            out_d   = '0;
            exc_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
`ifdef FCVT_FAST_NORM_EN
        mag_d   = mag_q << lz;
        exp_d   = exp_q - {3'd0, lz};
        state_d = S_ROUND;
`else
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
`endif
      end
      S_ROUND: begin
        out_d   = {sign_q, exp_rnd, mant_sum[22:0]};
        exc_d   = guard | sticky;
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      rm_q    <= 3'd0;
      mag_q   <= '0;
      exp_q   <= 8'd0;
      out_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      rm_q    <= rm_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
      exc_q   <= exc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_fcvt_s_w.sv
// Directed self-checking bench for fcvt_s_w; expected values are hand-computed binary32 encodings.
module tb_fcvt_s_w;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        signed_op;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        exception;

  int checks = 0;
  int errors = 0;

  fcvt_s_w #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .signed_op (signed_op),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .exception (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Cycles from the accept edge (counted as 1) until out_valid is seen: 3+lz, fixed 3 when fast.
  function automatic int nz_latency(input int lz);
`ifdef FCVT_FAST_NORM_EN
    return 3;
`else
    return 3 + lz;
`endif
  endfunction

  // Issue one request, measure latency, check result, then complete the handshake.
  task automatic convert(input string tag, input logic [31:0] av, input logic sop,
                         input logic [2:0] rmv, input logic [31:0] exp_out,
                         input logic exp_exc, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a         = av;
    signed_op = sop;
    rm        = rmv;
    @(negedge clk);
    in_valid  = 1'b0;
    a         = 32'hDEAD_BEEF;
    rm        = 3'd6;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " out"}, out, exp_out);
    check({tag, " nx"}, {31'd0, exception}, {31'd0, exp_exc});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    bit seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 32'd0;
    signed_op = 1'b0;
    rm        = 3'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out", out, 32'h0000_0000);
    check("reset nx", {31'd0, exception}, 32'd0);
    rst = 1'b0;

    convert("one s rne",      32'h0000_0001, 1'b1, 3'd0, 32'h3F80_0000, 1'b0, nz_latency(31));
    convert("three s rne",    32'h0000_0003, 1'b1, 3'd0, 32'h4040_0000, 1'b0, nz_latency(30));
    convert("m1 s rne",       32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0, nz_latency(31));
    convert("ffff u rne",     32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 1'b1, nz_latency(0));
    convert("ffff u rtz",     32'hFFFF_FFFF, 1'b0, 3'd1, 32'h4F7F_FFFF, 1'b1, nz_latency(0));
    convert("min s",          32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 1'b0, nz_latency(0));
    convert("min u",          32'h8000_0000, 1'b0, 3'd0, 32'h4F00_0000, 1'b0, nz_latency(0));
    convert("2p24p1 u rne",   32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, nz_latency(7));
    convert("2p24p1 s rup",   32'h0100_0001, 1'b1, 3'd3, 32'h4B80_0001, 1'b1, nz_latency(7));
    convert("2p24p1 u rtz",   32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1, nz_latency(7));
    convert("2p24p1 s rmm",   32'h0100_0001, 1'b1, 3'd4, 32'h4B80_0001, 1'b1, nz_latency(7));
    convert("2p24p1 s rdn",   32'h0100_0001, 1'b1, 3'd2, 32'h4B80_0000, 1'b1, nz_latency(7));
    convert("neg2p24p1 rdn",  32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0001, 1'b1, nz_latency(7));
    convert("neg2p24p1 rup",  32'hFEFF_FFFF, 1'b1, 3'd3, 32'hCB80_0000, 1'b1, nz_latency(7));
    convert("tie odd rne",    32'h0100_0003, 1'b0, 3'd0, 32'h4B80_0002, 1'b1, nz_latency(7));
    convert("tie odd rm7",    32'h0100_0003, 1'b0, 3'd7, 32'h4B80_0002, 1'b1, nz_latency(7));
    convert("zero u rup",     32'h0000_0000, 1'b0, 3'd3, 32'h0000_0000, 1'b0, 1);

    // Zero operand with the consumer stalled: result and flags must hold.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 32'h0000_0000;
    signed_op = 1'b1;
    rm        = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero lat1 valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("zero hold", {in_ready, out_valid, exception, 29'd0, out[0]},
            {1'b0, 1'b1, 1'b0, 29'd0, 1'b0});
      check("zero hold out", out, 32'h0000_0000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Leave a nonzero result in the output register, then abort a conversion in NORM.
    convert("pre abort", 32'h0000_0003, 1'b1, 3'd0, 32'h4040_0000, 1'b0, nz_latency(30));
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 32'h0000_0001;
    signed_op = 1'b1;
    rm        = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort out", out, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort no result", {31'd0, seen_valid}, 32'd0);
    convert("after abort", 32'h0100_0003, 1'b1, 3'd4, 32'h4B80_0002, 1'b1, nz_latency(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcvt_s_w.md
# fcvt_s_w

Multi-cycle integer-to-single-precision converter for the RV32F pipeline, implementing FCVT.S.W (signed) and FCVT.S.WU (unsigned). It works in the opposite direction to the FP compare unit: it consumes a 32-bit integer operand and produces an IEEE-754 binary32 result. It sits in the Float execute cluster behind a valid/ready handshake, so the pipeline stalls while a conversion is in flight. It raises the inexact flag through `exception`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request. High only in IDLE.
- `a` in WIDTH: integer operand.
- `signed_op` in 1: 1 = FCVT.S.W, 0 = FCVT.S.WU.
- `rm` in 3: rounding mode. 0 = RNE, 1 = RTZ, 2 = RDN, 3 = RUP, 4 = RMM. Values 5–7 behave as RNE; DYN is resolved upstream.
- `out_valid` out 1: result valid. Held until accepted.
- `out_ready` in 1: consumer accepts the result.
- `out` out WIDTH: binary32 result. Registered.
- `exception` out 1: inexact (NX). Registered, qualified by `out_valid`.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- **IDLE.** On `in_valid & in_ready`, capture the following:
  - sign = `signed_op & a[31]`.
  - mag = sign ? -a : a, 32-bit unsigned. 0x80000000 signed gives mag 0x80000000.
  - rm.
  - exp = 158 (127+31), 8 bits.
  - If mag == 0, go to DONE with `out` = 0x00000000 and `exception` = 0. The result is never −0.
  - Otherwise go to NORM.
- **NORM.**
  - If mag[31] = 1, go to ROUND.
  - Otherwise mag <<= 1, exp -= 1, and stay in NORM.
  - Minimum exp reached is 127.
- **ROUND.** Field extraction:
  - mant = mag[30:8], lsb = mag[8], g = mag[7], s = |mag[6:0].
  - inc by mode:
    - RNE: g&(s|lsb)
    - RTZ: 0
    - RDN: sign&(g|s)
    - RUP: ~sign&(g|s)
    - RMM: g
  - Compute {c, m} = {1'b0, mant} + inc (24 bits). If c = 1, then m = 0 and exp += 1.
  - Maximum exp is 159, so overflow is impossible.
  - `out` = {sign, exp, m}; `exception` = g|s. Go to DONE.
- **DONE.**
  - `out_valid` = 1. `out` and `exception` stay stable while `out_ready` = 0.
  - On `out_ready` = 1, go to IDLE.
  - `in_ready` stays 0 in DONE, so there is no request/response overlap.
- `in_valid` outside IDLE is ignored. `a`, `signed_op` and `rm` need to be valid only in the accept cycle.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `out` = 0, `exception` = 0, internal mag/exp = 0.
- Accept at edge T. Let lz = leading zeros of mag.
  - Nonzero, iterative build: NORM lasts lz+1 cycles. `out_valid` rises after edge T+3+lz, so latency is 3 to 34 cycles.
  - Nonzero, fast build: NORM lasts exactly 1 cycle. `out_valid` rises after edge T+3.
  - Zero operand: `out_valid` rises after edge T+1.
- The handshake edge with `out_valid & out_ready` returns to IDLE. `in_ready` = 1 in the next cycle, so the earliest following accept is one cycle after the result handshake.
- Asserting `rst` in any state forces IDLE immediately. The in-flight conversion is dropped and no `out_valid` is produced for it.

## Configuration
- `FCVT_FAST_NORM_EN` defined:
  - NORM computes lz with a priority encoder.
  - It barrel-shifts mag left by lz and subtracts lz from exp in one cycle.
  - Latency is a fixed 3 cycles for nonzero operands.
- `FCVT_FAST_NORM_EN` undefined:
  - One-bit-per-cycle shift loop, as described in Operation.
  - Smaller area, data-dependent latency.
- `out` and `exception` are bit-identical in both builds.

## Test plan
- a = 0x00000001, signed, RNE:
  - `out` = 0x3F800000, `exception` = 0.
  - `out_valid` at T+34 (iterative) or T+3 (fast).
- a = 0xFFFFFFFF:
  - signed → 0xBF800000, `exception` 0.
  - unsigned RNE → 0x4F800000, `exception` 1.
  - unsigned RTZ → 0x4F7FFFFF, `exception` 1.
- a = 0x80000000:
  - signed → 0xCF000000, `exception` 0.
  - unsigned → 0x4F000000, `exception` 0.
- a = 0x01000001 (2^24+1), unsigned or signed:
  - RNE → 0x4B800000, `exception` 1 (tie to even).
  - RUP → 0x4B800001.
  - RTZ → 0x4B800000.
  - RMM → 0x4B800001.
  - a = −(2^24+1), signed, RDN → 0xCB800001.
- a = 0, signed, any rm:
  - `out` = 0x00000000, `exception` 0, `out_valid` at T+1.
  - Hold `out_ready` = 0 for 5 cycles: `out`, `out_valid` and `exception` stay stable, and `in_ready` stays 0.
- Accept a = 0x00000001 (iterative build), then assert `rst` during NORM:
  - Same cycle: `in_ready` = 1, `out_valid` = 0, `out` = 0.
  - No result appears afterward.
  - The next request converts correctly.
